// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   state_t         receive FSM states (IDLE, DATA, PARITY, STOP)
//   BREAK_CODE      scan-code prefix announcing a key release
//   EXT_CODE        scan-code prefix announcing an extended key
//   FRAME_DATA_BITS data bits carried by one PS/2 frame
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [7:0]  BREAK_CODE      = 8'hF0;
    localparam logic [7:0]  EXT_CODE        = 8'hE0;
    localparam int unsigned FRAME_DATA_BITS = 8;

endpackage : ps2_pkg

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: brings the raw PS/2 pins into the clk domain, debounces the
// PS/2 clock and strobes once per falling edge of the debounced clock.
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   ps2_clk   in   raw PS/2 clock pin
//   ps2_data  in   raw PS/2 data pin
//   data_sync out  synchronized PS/2 data
//   bit_edge  out  one-cycle strobe on a 1->0 transition of the filtered clock
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic bit_edge
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronizers, debounce counter and edge strobe.
    // cnt_q counts consecutive synced samples that differ from the filtered
    // level; any sample agreeing with the filtered level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            bit_edge    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            bit_edge    <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_q   <= clk_sync_q[1];
                cnt_q    <= '0;
                // Filtered level was 1 and is flipping, so this is a falling edge.
                bit_edge <= filt_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign data_sync = data_sync_q[1];

endmodule : ps2_clk_filter

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard frame receiver (start, 8 data LSB-first, odd parity,
// stop). Presents the last accepted scan code as a held byte.
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   ps2_clk    in   raw PS/2 clock pin
//   ps2_data   in   raw PS/2 data pin
//   code_o     out  current scan code, held until next update
//   code_valid out  one-cycle pulse when code_o is (re)written
//   rx_err     out  one-cycle pulse on start, parity, stop-bit or timeout error
// Build option: define PS2_BREAK_FILTER_EN to consume F0/E0 prefixes so that
// code_o shows a key only while it is held (release clears it to 8'h00).
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       code_valid,
    output logic       rx_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BIT_W = $clog2(FRAME_DATA_BITS);

    logic             data_sync;
    logic             bit_edge;
    state_t           state_q;
    state_t           state_d;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             timeout_hit;
    logic             start_err;
    logic             frame_ok;
    logic             frame_bad;

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q;
    logic ext_q;
`endif

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_sync),
        .bit_edge  (bit_edge)
    );

    // A bit edge on the terminal count wins over the timeout.
    assign timeout_hit = (state_q != IDLE) && !bit_edge &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (bit_edge) begin
            unique case (state_q)
                IDLE:    if (!data_sync) state_d = DATA;
                DATA:    if (bit_cnt_q == BIT_W'(FRAME_DATA_BITS - 1)) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM output decode: frame verdicts raised on the deciding bit edge.
    always_comb begin
        start_err = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (bit_edge) begin
            if (state_q == IDLE) begin
                start_err = data_sync;
            end else if (state_q == STOP) begin
                frame_ok  = data_sync && ((^shift_q ^ parity_q) == 1'b1);
                frame_bad = !frame_ok;
            end
        end
    end

    // Frame datapath: bit counter, shift register, parity capture, timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE || bit_edge || timeout_hit) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end

            if (bit_edge) begin
                unique case (state_q)
                    IDLE: bit_cnt_q <= '0;
                    DATA: begin
                        shift_q   <= {data_sync, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                    PARITY:  parity_q <= data_sync;
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs and optional break/extended-prefix handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_o     <= 8'h00;
            code_valid <= 1'b0;
            rx_err     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
`endif
        end else begin
            code_valid <= 1'b0;
            rx_err     <= start_err | frame_bad | timeout_hit;
`ifdef PS2_BREAK_FILTER_EN
            if (frame_ok) begin
                if (shift_q == BREAK_CODE) begin
                    brk_q <= 1'b1;
                end else if (shift_q == EXT_CODE) begin
                    ext_q <= 1'b1;
                end else begin
                    // A release only clears the code it matches.
                    if (brk_q) begin
                        if (shift_q == code_o) begin
                            code_o     <= 8'h00;
                            code_valid <= 1'b1;
                        end
                    end else begin
                        code_o     <= shift_q;
                        code_valid <= 1'b1;
                    end
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                end
            end
`else
            if (frame_ok) begin
                code_o     <= shift_q;
                code_valid <= 1'b1;
            end
`endif
        end
    end

endmodule : ps2_rx

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed and randomized frames against a behavioural model of
// the receiver (frame -> accept/reject, optional break-prefix handling).
module tb_ps2_rx;

    localparam int unsigned TB_FILTER  = 8;
    localparam int unsigned TB_TIMEOUT = 1000;
    localparam int          HALF       = 40;   // PS/2 half period in clk cycles
    localparam int          SETTLE     = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code_o;
    logic       code_valid;
    logic       rx_err;

    int vectors     = 0;
    int miscompares = 0;

    // Observed pulse counts.
    int v_seen = 0;
    int e_seen = 0;
    bit both_seen = 1'b0;

    // Reference model state.
    logic [7:0] exp_code;
    int         exp_v;
    int         exp_e;
    bit         m_brk;
    bit         m_ext;

    ps2_rx #(
        .FILTER_LEN     (TB_FILTER),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_o     (code_o),
        .code_valid (code_valid),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (code_valid) v_seen <= v_seen + 1;
        if (rx_err) e_seen <= e_seen + 1;
        if (code_valid && rx_err) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".code"}, 32'(code_o), 32'(exp_code));
        check({tag, ".valid_pulses"}, 32'(v_seen), 32'(exp_v));
        check({tag, ".err_pulses"}, 32'(e_seen), 32'(exp_e));
        check({tag, ".valid_and_err"}, 32'(both_seen), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-side transmission of the first n bits of a frame (LSB first).
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        wait_cycles(HALF / 2);
        ps2_data = 1'b1;
    endtask

    function automatic logic odd_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Model of what one complete frame does to the outputs.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stp);
        bit ok;
        ok = (stp == 1'b1) && ((($countones(b) + int'(par)) % 2) == 1);
        if (!ok) begin
            exp_e++;
            return;
        end
`ifdef PS2_BREAK_FILTER_EN
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (!m_brk) begin
                exp_code = b;
                exp_v++;
            end else if (b == exp_code) begin
                exp_code = 8'h00;
                exp_v++;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
`else
        exp_code = b;
        exp_v++;
`endif
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic par, input logic stp);
        send_bits({stp, par, b, 1'b0}, 11);
        model_frame(b, par, stp);
        wait_cycles(SETTLE);
        check_all(tag);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b);
        frame(tag, b, odd_parity(b), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        #1;
        exp_code = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        check("reset.code", 32'(code_o), 32'h00);
        check("reset.valid", 32'(code_valid), 32'd0);
        check("reset.err", 32'(rx_err), 32'd0);
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(4);
    endtask

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stp;
        int         sel;

        exp_v = 0;
        exp_e = 0;
        do_reset();
        check_all("after_reset");

        // Good frame 0x1C (parity bit 0).
        frame("frame_1c", 8'h1C, 1'b0, 1'b1);

        // Same byte with wrong parity.
        frame("bad_parity", 8'h1C, 1'b1, 1'b1);

        // Bad stop bit.
        frame("bad_stop", 8'h5A, odd_parity(8'h5A), 1'b0);

        // Start bit of 1 while idle.
        send_bits(11'h001, 1);
        exp_e++;
        wait_cycles(SETTLE);
        check_all("bad_start");

        // Partial frame then silence: timeout error, code unchanged.
        send_bits({1'b1, odd_parity(8'h77), 8'h77, 1'b0}, 5);
        wait_cycles(TB_TIMEOUT + 100);
        exp_e++;
        check_all("timeout");
        good_frame("after_timeout", 8'h23);

        // Make/break sequence.
        good_frame("mk_1b", 8'h1B);
        good_frame("brk_f0", 8'hF0);
        good_frame("rel_1b", 8'h1B);

        // Short low glitch on ps2_clk must not register as an edge.
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_cycles(6);
        ps2_clk = 1'b1;
        wait_cycles(2);
        ps2_data = 1'b1;
        wait_cycles(SETTLE);
        check_all("glitch");

        // Reset mid-frame, then a fresh frame.
        send_bits({1'b1, odd_parity(8'h2B), 8'h2B, 1'b0}, 4);
        do_reset();
        check_all("mid_reset");
        good_frame("after_reset_2b", 8'h2B);

        // Randomized frames including prefixes, repeats and corrupt frames.
        for (int i = 0; i < 20; i++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0:       b = 8'hF0;
                1:       b = 8'hE0;
                2:       b = exp_code;
                default: b = 8'($urandom_range(0, 255));
            endcase
            par = odd_parity(b);
            if ($urandom_range(0, 5) == 0) par = ~par;
            stp = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            frame($sformatf("rand%0d", i), b, par, stp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ps2_rx
